// File: rtl/layer_scan_scheduler.sv
// ---------------------------------------------------------------------------
// layer_scan_scheduler
//   Top-level sequencer for the 8x8x8 LED cube in multi-frame mode. For each
//   layer it reads 64 column bits from frame memory, hands them to the column
//   shift loader, then starts the layer activator and waits for it to finish.
//   After FRAME_REPEAT full scans it moves to the next stored frame, wrapping
//   at the runtime frame count num_frames_i.
//
//   Optional build macro: LAYER_BLANK_EN -- inserts BLANK_CYCLES dead cycles
//   (all strobes low) between the end of one layer and the counter update.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   enable            level: keep scanning while high
//   num_frames_i[2:0] frames in animation minus 1
//   mem_rd_en         one-cycle read strobe to frame memory
//   mem_rd_addr[5:0]  {frame, layer}
//   mem_rd_data[63:0] memory word, valid one cycle after mem_rd_en
//   col_load          one-cycle pulse, col_data valid on the same cycle
//   col_data[63:0]    registered copy of mem_rd_data
//   col_load_done     column loader finished shifting
//   act_start         one-cycle pulse to layer activator
//   act_layer[2:0]    layer index, stable from act_start until act_done
//   act_done          layer activator finished its hold time
//   cur_frame[2:0]    frame currently displayed
//   frame_tick        one-cycle pulse when the frame advances
//   busy              high in any state other than IDLE
// ---------------------------------------------------------------------------
module layer_scan_scheduler #(
  parameter int unsigned NUM_LAYERS   = 8,
  parameter int unsigned FRAME_REPEAT = 4,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [2:0]  num_frames_i,
  output logic        mem_rd_en,
  output logic [5:0]  mem_rd_addr,
  input  logic [63:0] mem_rd_data,
  output logic        col_load,
  output logic [63:0] col_data,
  input  logic        col_load_done,
  output logic        act_start,
  output logic [2:0]  act_layer,
  input  logic        act_done,
  output logic [2:0]  cur_frame,
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam logic [7:0] LAST_SCAN  = 8'(FRAME_REPEAT - 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    CAPTURE,
    LOAD,
    WAIT_LOAD,
    START,
    WAIT_ACT,
    BLANK,
    ADVANCE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  layer;
  logic [2:0]  frame;
  logic [7:0]  scan;
  logic        tick_q;

`ifdef LAYER_BLANK_EN
  logic [3:0]  blank_cnt;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; handshakes are only looked at inside their wait state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (enable) state_nx = FETCH;
      FETCH:     state_nx = CAPTURE;
      CAPTURE:   state_nx = LOAD;
      LOAD:      state_nx = WAIT_LOAD;
      WAIT_LOAD: if (col_load_done) state_nx = START;
      START:     state_nx = WAIT_ACT;
`ifdef LAYER_BLANK_EN
      WAIT_ACT:  if (act_done) state_nx = BLANK;
      BLANK:     if (blank_cnt == 4'(BLANK_CYCLES - 1)) state_nx = ADVANCE;
`else
      WAIT_ACT:  if (act_done) state_nx = ADVANCE;
`endif
      ADVANCE:   state_nx = enable ? FETCH : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Layer/scan/frame counters and the captured column word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer    <= '0;
      frame    <= '0;
      scan     <= '0;
      col_data <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (state == CAPTURE) begin
        col_data <= mem_rd_data;
      end
      if (state == ADVANCE) begin
        if (layer < LAST_LAYER) begin
          layer <= layer + 3'd1;
        end else begin
          layer <= '0;
          if (scan == LAST_SCAN) begin
            scan   <= '0;
            // A frame count shrunk below the current frame also wraps to 0
            frame  <= (frame >= num_frames_i) ? 3'd0 : frame + 3'd1;
            tick_q <= 1'b1;
          end else begin
            scan <= scan + 8'd1;
          end
        end
      end
    end
  end

`ifdef LAYER_BLANK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_cnt <= '0;
    end else if (state == BLANK) begin
      blank_cnt <= blank_cnt + 4'd1;
    end else begin
      blank_cnt <= '0;
    end
  end
`endif

  // Outputs decoded from state; layer only changes in ADVANCE, so act_layer
  // is naturally stable across the activator handshake
  always_comb begin
    mem_rd_en   = (state == FETCH);
    mem_rd_addr = {frame, layer};
    col_load    = (state == LOAD);
    act_start   = (state == START);
    act_layer   = layer;
    cur_frame   = frame;
    frame_tick  = tick_q;
    busy        = (state != IDLE);
  end

endmodule
